// File: rtl/pa_pkg.sv
// Shared types for the PA memory arbiter: requester/tag encoding, FSM states
// and the default burst length.
package pa_pkg;

  typedef enum logic [1:0] {
    WT = 2'd0,
    DT = 2'd1,
    RS = 2'd2
  } owner_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int BURST_LEN_DEF = 16;

  // Round-robin successor over the three requesters.
  function automatic owner_e next_owner(input owner_e o);
    return (o == RS) ? WT : owner_e'(o + 2'd1);
  endfunction

endpackage

// File: rtl/pa_tag_fifo.sv
// Synchronous FIFO of 1-bit return tags (0 = weight, 1 = data) with a
// combinational head so a read return can be routed in the same cycle.
module pa_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic tag_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr_q;
  logic [PW:0] rd_ptr_q;
  logic        tags_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = tags_q[rd_ptr_q[PW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) tags_q[wr_ptr_q[PW-1:0]] <= tag_i;
  end

endmodule

// File: rtl/pa_mem_arbiter.sv
// Burst-locked round-robin arbiter sharing one memory port between weight
// reads, data reads and result writes. PA_ARB_RS_PRIO_EN gives RS absolute priority in IDLE.
module pa_mem_arbiter
  import pa_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wt_req,
  input  logic [ADDR_W-1:0] wt_addr,
  output logic              wt_gnt,
  output logic              wt_rvalid,
  output logic [DATA_W-1:0] wt_rdata,
  input  logic              dt_req,
  input  logic [ADDR_W-1:0] dt_addr,
  output logic              dt_gnt,
  output logic              dt_rvalid,
  output logic [DATA_W-1:0] dt_rdata,
  input  logic              rs_req,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] rs_wdata,
  output logic              rs_gnt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  state_e        state_q;
  owner_e        owner_q;
  owner_e        rr_q;
  logic [CW-1:0] beat_cnt_q;
  logic          err_q;
  logic          err_d;

  logic          fifo_full, fifo_empty, fifo_head;
  logic [2:0]    elig;
  owner_e        o0, o1, o2, pick_owner;
  logic          pick_valid;
  logic          owner_req;
  logic [ADDR_W-1:0] owner_addr;
  logic          in_burst, beat, burst_end;

  // Reads may only start a burst while a tag slot is free.
  assign elig = {rs_req, dt_req & ~fifo_full, wt_req & ~fifo_full};

  always_comb begin
    o0         = rr_q;
    o1         = next_owner(o0);
    o2         = next_owner(o1);
    pick_valid = |elig;
    pick_owner = o0;
    if (elig[o2]) pick_owner = o2;
    if (elig[o1]) pick_owner = o1;
    if (elig[o0]) pick_owner = o0;
`ifdef PA_ARB_RS_PRIO_EN
    if (rs_req) pick_owner = RS;
`else
`endif
  end

  always_comb begin
    owner_req  = 1'b0;
    owner_addr = '0;
    case (owner_q)
      WT:      begin owner_req = wt_req; owner_addr = wt_addr; end
      DT:      begin owner_req = dt_req; owner_addr = dt_addr; end
      RS:      begin owner_req = rs_req; owner_addr = rs_addr; end
      default: begin owner_req = 1'b0;   owner_addr = '0;      end
    endcase
  end

  assign in_burst  = (state_q == BURST);
  assign mem_req   = in_burst & owner_req & ((owner_q == RS) | ~fifo_full);
  assign beat      = mem_req & mem_gnt;
  assign burst_end = (beat && beat_cnt_q == LAST_BEAT) || !owner_req;

  assign mem_we    = in_burst & (owner_q == RS);
  assign mem_addr  = in_burst ? owner_addr : '0;
  assign mem_wdata = mem_we ? rs_wdata : '0;
  assign wt_gnt    = beat & (owner_q == WT);
  assign dt_gnt    = beat & (owner_q == DT);
  assign rs_gnt    = beat & (owner_q == RS);

  // Returns are steered by the oldest outstanding tag; data goes to both streams.
  assign wt_rvalid = mem_rvalid & ~fifo_empty & ~fifo_head & ~rst;
  assign dt_rvalid = mem_rvalid & ~fifo_empty &  fifo_head & ~rst;
  assign wt_rdata  = mem_rdata;
  assign dt_rdata  = mem_rdata;
  assign err_d     = err_q | (mem_rvalid & fifo_empty);
  assign err       = err_q;

  pa_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (beat & (owner_q != RS)),
    .tag_i   (owner_q == DT),
    .pop_i   (mem_rvalid),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= WT;
      rr_q       <= WT;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q    <= BURST;
            owner_q    <= pick_owner;
            beat_cnt_q <= '0;
          end
        end
        BURST: begin
          if (beat) beat_cnt_q <= beat_cnt_q + 1'b1;
          if (burst_end) begin
            state_q <= IDLE;
            rr_q    <= next_owner(owner_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pa_mem_arbiter.sv
// Scoreboard bench for pa_mem_arbiter: stimulus queues expected beats and
// returns, a negedge monitor pops and compares them as the DUT produces them.
module tb_pa_mem_arbiter;
  import pa_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wt_req = 0, dt_req = 0, rs_req = 0;
  logic [31:0] wt_addr = 0, dt_addr = 0, rs_addr = 0, rs_wdata = 0;
  logic        wt_gnt, dt_gnt, rs_gnt, wt_rvalid, dt_rvalid, err;
  logic [31:0] wt_rdata, dt_rdata;
  logic        mem_req, mem_we, mem_gnt = 1'b1, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct { int own; logic [31:0] addr; logic [31:0] wdata; } beat_t;
  typedef struct { int own; logic [31:0] data; } ret_t;

  beat_t       exp_beats[$];
  ret_t        exp_rets[$];
  logic [31:0] pend[$];
  int          beat_cyc[$];
  int          rv_cyc[$];
  int          n_vec = 0, n_fail = 0, cyc = 0;
  int          start_cyc[3];
  int          orphan_req = 0;
  bit          rv_en = 1'b0;

  pa_mem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .wt_req(wt_req), .wt_addr(wt_addr), .wt_gnt(wt_gnt), .wt_rvalid(wt_rvalid), .wt_rdata(wt_rdata),
    .dt_req(dt_req), .dt_addr(dt_addr), .dt_gnt(dt_gnt), .dt_rvalid(dt_rvalid), .dt_rdata(dt_rdata),
    .rs_req(rs_req), .rs_addr(rs_addr), .rs_wdata(rs_wdata), .rs_gnt(rs_gnt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_beats(input int own, input logic [31:0] base, input int from, input int n);
    beat_t b;
    ret_t  r;
    for (int i = 0; i < n; i++) begin
      b.own   = own;
      b.addr  = base + 32'(4 * (from + i));
      b.wdata = (own == 2) ? 32'hC0DE_0000 + 32'(from + i) : 32'h0;
      exp_beats.push_back(b);
      if (own != 2) begin
        r.own  = own;
        r.data = mdata(b.addr);
        exp_rets.push_back(r);
      end
    end
  endtask

  task automatic drive(input int s, input logic r, input logic [31:0] a, input logic [31:0] w);
    case (s)
      0:       begin wt_req = r; wt_addr = a; end
      1:       begin dt_req = r; dt_addr = a; end
      default: begin rs_req = r; rs_addr = a; rs_wdata = w; end
    endcase
  endtask

  // Behaves like a PA stream: holds req/addr/wdata until each gnt, then advances.
  task automatic requester(input int s, input int n, input logic [31:0] base);
    int   k;
    int   t;
    logic g;
    k = 0;
    t = 0;
    @(posedge clk); #1;
    drive(s, 1'b1, base, 32'hC0DE_0000);
    start_cyc[s] = cyc;
    while (k < n && t < 400) begin
      @(negedge clk);
      t++;
      g = (s == 0) ? wt_gnt : (s == 1) ? dt_gnt : rs_gnt;
      if (g) k++;
      @(posedge clk); #1;
      drive(s, k < n, base + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
    end
    if (k < n) begin
      n_vec++;
      n_fail++;
      $display("FAIL req_timeout: stream %0d got %0d beats, needed %0d", s, k, n);
      drive(s, 1'b0, base, 32'h0);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_beats.size() != 0 || exp_rets.size() != 0) && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("drain_beats_left", exp_beats.size(), 0);
    chk("drain_rets_left", exp_rets.size(), 0);
  endtask

  // Memory model: in-order read returns, one per cycle while enabled.
  initial begin
    int orphan_seen;
    orphan_seen = 0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (orphan_req != orphan_seen) begin
        orphan_seen = orphan_req;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
      end else if (rv_en && pend.size() > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mdata(pend.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] g;
    beat_t      b;
    ret_t       r;
    if (!rst) begin
      g = {rs_gnt, dt_gnt, wt_gnt};
      if (mem_req && mem_gnt) begin
        beat_cyc.push_back(cyc);
        if (!mem_we) pend.push_back(mem_addr);
        $display("beat   cyc %0d own %b addr %h we %b wdata %h", cyc, g, mem_addr, mem_we, mem_wdata);
        if (exp_beats.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_beat: addr %h, required no beat", mem_addr);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_gnt_owner", {29'd0, g}, 32'(3'b001 << b.own));
          chk("beat_addr", mem_addr, b.addr);
          chk("beat_we", {31'd0, mem_we}, (b.own == 2) ? 32'd1 : 32'd0);
          if (b.own == 2) chk("beat_wdata", mem_wdata, b.wdata);
        end
      end else begin
        chk("stray_gnt", {29'd0, g}, 32'd0);
      end
      if (wt_rvalid || dt_rvalid) begin
        rv_cyc.push_back(cyc);
        $display("return cyc %0d wt %b dt %b data %h", cyc, wt_rvalid, dt_rvalid, wt_rdata);
        if (exp_rets.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_rvalid: wt %b dt %b, required none", wt_rvalid, dt_rvalid);
        end else begin
          r = exp_rets.pop_front();
          chk("ret_stream", {30'd0, dt_rvalid, wt_rvalid}, (r.own == 1) ? 32'd2 : 32'd1);
          chk("ret_wt_rdata", wt_rdata, r.data);
          chk("ret_dt_rdata", dt_rdata, r.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state, during and just after reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {24'd0, mem_req, mem_we, wt_gnt, dt_gnt, rs_gnt, wt_rvalid, dt_rvalid, err}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", {24'd0, mem_req, mem_we, wt_gnt, dt_gnt, rs_gnt, wt_rvalid, dt_rvalid, err}, 32'd0);
    rv_en = 1'b1;

    // 20 weight beats: 16-beat burst, one dead cycle, 4 more.
    beat_cyc.delete();
    push_beats(0, 32'h0000_1000, 0, 20);
    requester(0, 20, 32'h0000_1000);
    wait_drain();
    chk("t1_nbeats", beat_cyc.size(), 20);
    if (beat_cyc.size() == 20)
      for (int i = 0; i < 20; i++)
        chk("t1_beat_cycle", beat_cyc[i] - start_cyc[0], (i < 16) ? i + 1 : i + 2);

    // rr now points at DT; DT and RS request together.
`ifdef PA_ARB_RS_PRIO_EN
    push_beats(2, 32'h0000_3000, 0, 1);
    push_beats(1, 32'h0000_2000, 0, 1);
`else
    push_beats(1, 32'h0000_2000, 0, 1);
    push_beats(2, 32'h0000_3000, 0, 1);
`endif
    fork
      requester(1, 1, 32'h0000_2000);
      requester(2, 1, 32'h0000_3000);
    join
    wait_drain();

    // All three held: full bursts in round-robin order.
`ifdef PA_ARB_RS_PRIO_EN
    push_beats(2, 32'h0000_3100, 0, 16);
    push_beats(0, 32'h0000_1100, 0, 16);
    push_beats(1, 32'h0000_2100, 0, 16);
`else
    push_beats(0, 32'h0000_1100, 0, 16);
    push_beats(1, 32'h0000_2100, 0, 16);
    push_beats(2, 32'h0000_3100, 0, 16);
`endif
    push_beats(0, 32'h0000_1100, 16, 16);
    fork
      requester(0, 32, 32'h0000_1100);
      requester(1, 16, 32'h0000_2100);
      requester(2, 16, 32'h0000_3100);
    join
    wait_drain();

    // Outstanding-read limit: returns withheld, then released.
    rv_en = 1'b0;
    beat_cyc.delete();
    rv_cyc.delete();
    push_beats(1, 32'h0000_2200, 0, 6);
    fork
      requester(1, 6, 32'h0000_2200);
      begin
        t = 0;
        while (beat_cyc.size() < 4 && t < 50) begin
          @(negedge clk); #1;
          t++;
        end
        repeat (3) begin
          @(negedge clk);
          chk("t3_blocked_mem_req", {31'd0, mem_req}, 32'd0);
        end
        rv_en = 1'b1;
      end
    join
    wait_drain();
    chk("t3_nbeats", beat_cyc.size(), 6);
    if (beat_cyc.size() == 6 && rv_cyc.size() > 0)
      chk("t3_resume_cycle", beat_cyc[4], rv_cyc[0] + 1);

    // Returns WT x2 then DT x2, all four outstanding at once.
    rv_en = 1'b0;
    push_beats(0, 32'h0000_1300, 0, 2);
    push_beats(1, 32'h0000_2300, 0, 2);
    requester(0, 2, 32'h0000_1300);
    requester(1, 2, 32'h0000_2300);
    @(negedge clk);
    rv_en = 1'b1;
    wait_drain();

    // Orphan return: sets sticky err, no rvalid; only rst clears it.
    @(negedge clk);
    chk("t5_err_before", {31'd0, err}, 32'd0);
    orphan_req++;
    @(negedge clk);
    chk("t5_no_rvalid", {30'd0, dt_rvalid, wt_rvalid}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_err_sticky", {31'd0, err}, 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared", {31'd0, err}, 32'd0);
    chk("t5_outputs_after_rst", {27'd0, mem_req, wt_gnt, dt_gnt, rs_gnt, wt_rvalid | dt_rvalid}, 32'd0);

    chk("final_beats_left", exp_beats.size(), 0);
    chk("final_rets_left", exp_rets.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
